// File: rtl/cp0_unit_pkg.sv
// Shared CP0 decode constants, register selects and default handler vectors.
package cp0_unit_pkg;

   // Instruction field encodings for the COP0 group
   localparam logic [5:0] OP_COP0    = 6'b010000;
   localparam logic [4:0] RS_MF      = 5'b00000;
   localparam logic [4:0] RS_MT      = 5'b00100;
   localparam logic [4:0] RS_ERET    = 5'b10000;
   localparam logic [5:0] FUNCT_ERET = 6'b011000;

   // Default handler vectors and Status reset value
   localparam logic [31:0] VEC0_DEF       = 32'h0000_0800;
   localparam logic [31:0] VEC1_DEF       = 32'h0000_0C00;
   localparam logic [31:0] VEC2_DEF       = 32'h0000_1000;
   localparam logic [31:0] STATUS_RST_DEF = 32'h0000_0007;

   // CP0 register select, Inst[12:11]
   typedef enum logic [1:0] {
      SEL_STATUS = 2'b00,
      SEL_CAUSE  = 2'b01,
      SEL_EPC    = 2'b10,
      SEL_NONE   = 2'b11
   } cp0_sel_e;

   // Which handler vector the winning request maps to
   typedef enum logic [1:0] {
      VSEL_0 = 2'b00,
      VSEL_1 = 2'b01,
      VSEL_2 = 2'b10
   } cp0_vsel_e;

   // Handler service state; ExpBlock is high while in ST_HANDLER
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_HANDLER = 1'b1
   } cp0_state_e;

   // Zero-extend a 3-bit per-source field to a 32-bit register read
   function automatic logic [31:0] zext3(input logic [2:0] v);
      return {29'b0, v};
   endfunction

endpackage

// File: rtl/cp0_unit_prio_enc.sv
// Fixed-priority encoder over the three exception requests (0 > 1 > 2).
module cp0_prio_enc
   import cp0_unit_pkg::*;
(
   input  logic [2:0] i_req,
   output logic [2:0] o_clr,
   output cp0_vsel_e  o_vsel
);

   // Pick the lowest-numbered active request: one-hot clear plus vector select
   always_comb begin
      o_clr  = '0;
      o_vsel = VSEL_0;
      if (i_req[0]) begin
         o_clr  = 3'b001;
         o_vsel = VSEL_0;
      end else if (i_req[1]) begin
         o_clr  = 3'b010;
         o_vsel = VSEL_1;
      end else if (i_req[2]) begin
         o_clr  = 3'b100;
         o_vsel = VSEL_2;
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: exception latching/masking, EPC capture, vectoring and
// MFC0/MTC0/ERET handling for the single-cycle MIPS core.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] VEC0       = VEC0_DEF,
   parameter logic [31:0] VEC1       = VEC1_DEF,
   parameter logic [31:0] VEC2       = VEC2_DEF,
   parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Inst,
   input  logic [31:0] PCin,
   input  logic [31:0] Din,
   input  logic        ExpSrc0,
   input  logic        ExpSrc1,
   input  logic        ExpSrc2,
   input  logic        enable,
   output logic        ExRegWrite,
   output logic        IsEret,
   output logic        HasExp,
   output logic        ExpBlock,
   output logic [31:0] PCout,
   output logic [31:0] Dout
);

   logic [2:0]  r_status;
   logic [2:0]  r_cause;
   logic [31:0] r_epc;
   cp0_state_e  r_state;

   logic        w_cop0;
   logic        w_mtc0;
   logic        w_wr;
   cp0_sel_e    w_sel;
   logic [2:0]  w_src;
   logic [2:0]  w_req;
   logic [2:0]  w_clr;
   logic [2:0]  w_clear;
   logic [2:0]  w_pend_nxt;
   cp0_vsel_e   w_vsel;
   logic        w_unused_inst;

   assign w_cop0     = (Inst[31:26] == OP_COP0);
   assign ExRegWrite = w_cop0 && (Inst[25:21] == RS_MF);
   assign w_mtc0     = w_cop0 && (Inst[25:21] == RS_MT);
   assign IsEret     = w_cop0 && (Inst[25:21] == RS_ERET) && (Inst[5:0] == FUNCT_ERET);
   assign w_sel      = cp0_sel_e'(Inst[12:11]);
   assign w_wr       = enable && w_mtc0;
   assign w_unused_inst = ^{Inst[20:13], Inst[10:6]};

   assign w_src    = {ExpSrc2, ExpSrc1, ExpSrc0};
   assign w_req    = r_cause & r_status;
   assign ExpBlock = (r_state == ST_HANDLER);
   assign HasExp   = (|w_req) && !ExpBlock && !IsEret;

   cp0_prio_enc u_prio (
      .i_req  (w_req),
      .o_clr  (w_clr),
      .o_vsel (w_vsel)
   );

   // Only the request being taken this edge is cleared; new requests win over clear
   assign w_clear    = HasExp ? w_clr : '0;
   assign w_pend_nxt = (r_cause & ~w_clear) | w_src;

   // Status mask and Cause pending bits; an MTC0 to Cause still ORs in new requests
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_status <= STATUS_RST[2:0];
         r_cause  <= '0;
      end else begin
         if (w_wr && w_sel == SEL_STATUS)
            r_status <= Din[2:0];
         if (w_wr && w_sel == SEL_CAUSE)
            r_cause <= Din[2:0] | w_src;
         else
            r_cause <= w_pend_nxt;
      end
   end

   // EPC: exception entry captures the return PC ahead of any MTC0 to EPC
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_epc <= '0;
      else if (HasExp)
         r_epc <= PCin;
      else if (w_wr && w_sel == SEL_EPC)
         r_epc <= Din;
   end

   // Handler service state: enter on exception, leave on ERET
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else begin
         case (r_state)
            ST_IDLE:    if (HasExp) r_state <= ST_HANDLER;
            ST_HANDLER: if (IsEret) r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   // Next-PC override: EPC on ERET, vector on exception, otherwise EPC
   always_comb begin
      PCout = r_epc;
      if (!IsEret && HasExp) begin
         case (w_vsel)
            VSEL_0:  PCout = VEC0;
            VSEL_1:  PCout = VEC1;
            VSEL_2:  PCout = VEC2;
            default: PCout = VEC0;
         endcase
      end
   end

   // MFC0 read mux; unused bits and select 11 read as zero
   always_comb begin
      Dout = '0;
      case (w_sel)
         SEL_STATUS: Dout = zext3(r_status);
         SEL_CAUSE:  Dout = zext3(r_cause);
         SEL_EPC:    Dout = r_epc;
         default:    Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations queued with stimulus, drained at sample points.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Inst = '0;
   logic [31:0] PCin = 32'h0040_0000;
   logic [31:0] Din = '0;
   logic        ExpSrc0 = 1'b0;
   logic        ExpSrc1 = 1'b0;
   logic        ExpSrc2 = 1'b0;
   logic        enable = 1'b0;
   logic        ExRegWrite;
   logic        IsEret;
   logic        HasExp;
   logic        ExpBlock;
   logic [31:0] PCout;
   logic [31:0] Dout;

   localparam logic [31:0] I_NOP     = 32'h0000_0000;
   localparam logic [31:0] I_MF_STAT = 32'h4000_0000;
   localparam logic [31:0] I_MF_CAUS = 32'h4000_0800;
   localparam logic [31:0] I_MF_EPC  = 32'h4000_1000;
   localparam logic [31:0] I_MT_STAT = 32'h4080_0000;
   localparam logic [31:0] I_MT_EPC  = 32'h4080_1000;
   localparam logic [31:0] I_ERET    = 32'h4200_0018;

   cp0_unit #(
      .VEC0       (32'h0000_0800),
      .VEC1       (32'h0000_0C00),
      .VEC2       (32'h0000_1000),
      .STATUS_RST (32'h0000_0007)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Inst       (Inst),
      .PCin       (PCin),
      .Din        (Din),
      .ExpSrc0    (ExpSrc0),
      .ExpSrc1    (ExpSrc1),
      .ExpSrc2    (ExpSrc2),
      .enable     (enable),
      .ExRegWrite (ExRegWrite),
      .IsEret     (IsEret),
      .HasExp     (HasExp),
      .ExpBlock   (ExpBlock),
      .PCout      (PCout),
      .Dout       (Dout)
   );

   always #5 clk = ~clk;

   typedef enum logic [2:0] {
      HASEXP, BLOCK, REGW, ERET, PCOUT, DOUT
   } sig_e;

   typedef struct packed {
      sig_e        sig;
      logic [31:0] val;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic expect_out(input sig_e s, input logic [31:0] v);
      sb_t e;
      e.sig = s;
      e.val = v;
      sb_q.push_back(e);
   endtask

   // Compare every queued expectation against the current outputs
   task automatic drain();
      sb_t         e;
      logic [31:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sig)
            HASEXP:  obs = {31'b0, HasExp};
            BLOCK:   obs = {31'b0, ExpBlock};
            REGW:    obs = {31'b0, ExRegWrite};
            ERET:    obs = {31'b0, IsEret};
            PCOUT:   obs = PCout;
            default: obs = Dout;
         endcase
         check_val(e.sig.name(), obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      step();
      expect_out(HASEXP, 0); expect_out(BLOCK, 0); expect_out(REGW, 0);
      expect_out(ERET, 0);   expect_out(DOUT, 32'h7);
      drain();
      reset = 1'b0;
      step();

      // Single source-0 exception
      ExpSrc0 = 1'b1;
      step();
      ExpSrc0 = 1'b0;
      expect_out(HASEXP, 1); expect_out(PCOUT, 32'h0000_0800); expect_out(BLOCK, 0);
      drain();
      step();
      Inst = I_MF_CAUS;
      expect_out(HASEXP, 0); expect_out(BLOCK, 1); expect_out(REGW, 1); expect_out(DOUT, 0);
      drain();
      Inst = I_MF_EPC;
      expect_out(DOUT, 32'h0040_0000);
      drain();

      // MFC0 Status, MTC0 EPC gated by enable
      Inst = I_MF_STAT;
      expect_out(REGW, 1); expect_out(DOUT, 32'h7);
      drain();
      Inst = I_MT_EPC; Din = 32'h1234_5678; enable = 1'b0;
      expect_out(REGW, 0);
      drain();
      step();
      Inst = I_MF_EPC;
      expect_out(DOUT, 32'h0040_0000);
      drain();
      Inst = I_MT_EPC; enable = 1'b1;
      step();
      enable = 1'b0; Inst = I_MF_EPC;
      expect_out(DOUT, 32'h1234_5678);
      drain();

      // ERET while in handler
      Inst = I_ERET;
      expect_out(ERET, 1); expect_out(REGW, 0); expect_out(PCOUT, 32'h1234_5678);
      expect_out(HASEXP, 0);
      drain();
      step();
      Inst = I_NOP;
      expect_out(BLOCK, 0); expect_out(ERET, 0);
      drain();

      // Simultaneous sources 1 and 2: priority, then second entry after ERET
      ExpSrc1 = 1'b1; ExpSrc2 = 1'b1; PCin = 32'h0040_0100;
      step();
      ExpSrc1 = 1'b0; ExpSrc2 = 1'b0;
      expect_out(HASEXP, 1); expect_out(PCOUT, 32'h0000_0C00);
      drain();
      step();
      Inst = I_MF_CAUS;
      expect_out(BLOCK, 1); expect_out(HASEXP, 0); expect_out(DOUT, 32'h4);
      drain();
      Inst = I_ERET;
      expect_out(ERET, 1); expect_out(HASEXP, 0); expect_out(PCOUT, 32'h0040_0100);
      drain();
      step();
      Inst = I_NOP;
      expect_out(BLOCK, 0); expect_out(HASEXP, 1); expect_out(PCOUT, 32'h0000_1000);
      drain();
      step();
      Inst = I_MF_CAUS;
      expect_out(BLOCK, 1); expect_out(DOUT, 0);
      drain();
      Inst = I_ERET;
      step();
      Inst = I_NOP;
      expect_out(BLOCK, 0); expect_out(HASEXP, 0);
      drain();

      // Masked request stays pending, fires when unmasked
      Inst = I_MT_STAT; Din = 32'h0; enable = 1'b1;
      step();
      enable = 1'b0; Inst = I_MF_STAT;
      expect_out(DOUT, 0);
      drain();
      ExpSrc0 = 1'b1;
      step();
      ExpSrc0 = 1'b0; Inst = I_MF_CAUS;
      expect_out(HASEXP, 0); expect_out(DOUT, 32'h1);
      drain();
      step();
      expect_out(HASEXP, 0); expect_out(DOUT, 32'h1);
      drain();
      Inst = I_MT_STAT; Din = 32'h1; enable = 1'b1; PCin = 32'h0040_0200;
      step();
      enable = 1'b0; Inst = I_NOP;
      expect_out(HASEXP, 1); expect_out(PCOUT, 32'h0000_0800); expect_out(BLOCK, 0);
      drain();
      step();
      Inst = I_MF_EPC;
      expect_out(BLOCK, 1); expect_out(DOUT, 32'h0040_0200);
      drain();

      // Asynchronous reset mid-handler
      reset = 1'b1;
      expect_out(BLOCK, 0); expect_out(HASEXP, 0); expect_out(DOUT, 0);
      drain();
      Inst = I_MF_STAT;
      expect_out(DOUT, 32'h7);
      drain();
      Inst = I_MF_CAUS;
      expect_out(DOUT, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
